// File: rtl/vga_stream_pkg.sv
// Shared definitions for the VGA stream receive path:
// stream widths, field bit positions, counter limits, lock FSM states.
package vga_stream_pkg;

  localparam int STR_VGA_W = 23;
  localparam int STR_RGB_W = 26;

  localparam int X_LSB  = 0;
  localparam int Y_LSB  = 10;
  localparam int HSYNC  = 20;
  localparam int VSYNC  = 21;
  localparam int ACTIVE = 22;
  localparam int B      = 23;
  localparam int G      = 24;
  localparam int R      = 25;

  // Idle stream word: both syncs high (inactive), everything else zero.
  localparam logic [STR_RGB_W-1:0] STR_IDLE = 26'h0300000;

  localparam logic [10:0] HCNT_MAX = 11'd2047;
  localparam logic [9:0]  VCNT_MAX = 10'd1023;

  typedef logic [1:0] state_t;

  localparam state_t ST_SEARCH  = 2'd0;
  localparam state_t ST_MEASURE = 2'd1;
  localparam state_t ST_LOCKED  = 2'd2;

endpackage

// File: rtl/vga_stream_capture_sync_edge_det.sv
// 2-flop synchroniser for an active-low sync pin plus a one-cycle
// deassertion (0->1) pulse. Ports: clk_i, rst_i, d_i, sync_o, rise_o.
module sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);

  // [0],[1] synchronise; [2] is the previous synchronised value.
  logic [2:0] sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= 3'b111;
    end else begin
      sh_q <= {sh_q[1:0], d_i};
    end
  end

  assign sync_o = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/vga_stream_capture.sv
// Rebuilds the 26-bit strRGB stream from raw VGA pins and validates timing.
// Ports: px_clk, reset, vsync_in, hsync_in, r/g/b_in, strRGB, locked, line_period.
module vga_stream_capture
  import vga_stream_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_BACK      = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_BACK      = 33,
  parameter int H_TOL       = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                 px_clk,
  input  logic                 reset,
  input  logic                 vsync_in,
  input  logic                 hsync_in,
  input  logic                 r_in,
  input  logic                 g_in,
  input  logic                 b_in,
  output logic [STR_RGB_W-1:0] strRGB,
  output logic                 locked,
  output logic [10:0]          line_period
);

  localparam int CW = STR_RGB_W - STR_VGA_W;

  localparam logic [10:0] HB   = 11'(H_BACK);
  localparam logic [10:0] HE   = 11'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  HB10 = 10'(H_BACK);
  localparam logic [9:0]  VB   = 10'(V_BACK);
  localparam logic [9:0]  VE   = 10'(V_BACK + V_ACTIVE);
  localparam logic [11:0] TOL  = 12'(H_TOL);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  logic          vs_s, vs_rise;
  logic          hs_s, hs_rise;
  logic [CW-1:0] rgb_s1_q, rgb_s2_q;

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [10:0] lp_q, lp_d;
  logic [10:0] ref_q, ref_d;
  logic        ref_ok_q, ref_ok_d;
  logic [9:0]  lines_q, lines_d;
  logic        lines_ok_q, lines_ok_d;
  logic [3:0]  match_q, match_d;
  state_t      st_q, st_d;
  logic [STR_RGB_W-1:0] str_q, str_d;

  logic [10:0] period;
  logic        hsat, per_bad, lose, in_win, active;

  sync_edge_det u_vs (
    .clk_i  (px_clk),
    .rst_i  (reset),
    .d_i    (vsync_in),
    .sync_o (vs_s),
    .rise_o (vs_rise)
  );

  sync_edge_det u_hs (
    .clk_i  (px_clk),
    .rst_i  (reset),
    .d_i    (hsync_in),
    .sync_o (hs_s),
    .rise_o (hs_rise)
  );

  assign hsat = (hcnt_q == HCNT_MAX);

  // Period of the line just ended; pinned at the counter ceiling.
  assign period = hsat ? HCNT_MAX : hcnt_q + 11'd1;

  assign per_bad = ({1'b0, period} + TOL < {1'b0, ref_q})
                || ({1'b0, period} > {1'b0, ref_q} + TOL);

  always_comb begin
    hcnt_d = hsat ? hcnt_q : hcnt_q + 11'd1;
    if (hs_rise) hcnt_d = '0;
    vcnt_d = vcnt_q;
    if (hs_rise && vcnt_q != VCNT_MAX) vcnt_d = vcnt_q + 10'd1;
    if (vs_rise) vcnt_d = '0;
    lp_d = hs_rise ? period : lp_q;
  end

  always_comb begin
    st_d       = st_q;
    ref_d      = ref_q;
    ref_ok_d   = ref_ok_q;
    lines_d    = lines_q;
    lines_ok_d = lines_ok_q;
    match_d    = match_q;
    lose       = 1'b0;
    unique case (st_q)
      ST_SEARCH: begin
        if (vs_rise) begin
          st_d       = ST_MEASURE;
          ref_ok_d   = 1'b0;
          lines_ok_d = 1'b0;
          match_d    = '0;
        end
      end
      ST_MEASURE: begin
        if (hs_rise && !ref_ok_q) begin
          ref_d    = period;
          ref_ok_d = 1'b1;
        end
        if (hs_rise && ref_ok_q && per_bad) begin
          st_d = ST_SEARCH;
        end else if (vs_rise) begin
          lines_d    = vcnt_q;
          lines_ok_d = 1'b1;
          if (lines_ok_q && vcnt_q == lines_q) begin
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_N) st_d = ST_LOCKED;
          end else begin
            match_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        lose = (hs_rise && per_bad)
            || (vs_rise && vcnt_q != lines_q)
            || hsat;
        if (lose) st_d = ST_SEARCH;
      end
      default: st_d = ST_SEARCH;
    endcase
  end

  // Coordinates follow the counters' next values so they line up
  // with the colour sample currently leaving the synchroniser.
  assign in_win = (hcnt_d >= HB) && (hcnt_d < HE)
               && (vcnt_d >= VB) && (vcnt_d < VE);
  assign active = in_win && (st_q == ST_LOCKED) && !lose;

  always_comb begin
    str_d = '0;
    if (in_win) begin
      str_d[X_LSB +: 10] = hcnt_d[9:0] - HB10;
      str_d[Y_LSB +: 10] = vcnt_d - VB;
    end
    str_d[HSYNC]  = hs_s;
    str_d[VSYNC]  = vs_s;
    str_d[ACTIVE] = active;
    str_d[R]      = rgb_s2_q[2] & active;
    str_d[G]      = rgb_s2_q[1] & active;
    str_d[B]      = rgb_s2_q[0] & active;
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      rgb_s1_q   <= '0;
      rgb_s2_q   <= '0;
      hcnt_q     <= '0;
      vcnt_q     <= '0;
      lp_q       <= '0;
      ref_q      <= '0;
      ref_ok_q   <= 1'b0;
      lines_q    <= '0;
      lines_ok_q <= 1'b0;
      match_q    <= '0;
      st_q       <= ST_SEARCH;
      str_q      <= STR_IDLE;
    end else begin
      rgb_s1_q   <= {r_in, g_in, b_in};
      rgb_s2_q   <= rgb_s1_q;
      hcnt_q     <= hcnt_d;
      vcnt_q     <= vcnt_d;
      lp_q       <= lp_d;
      ref_q      <= ref_d;
      ref_ok_q   <= ref_ok_d;
      lines_q    <= lines_d;
      lines_ok_q <= lines_ok_d;
      match_q    <= match_d;
      st_q       <= st_d;
      str_q      <= str_d;
    end
  end

  assign strRGB      = str_q;
  assign locked      = (st_q == ST_LOCKED);
  assign line_period = lp_q;

endmodule

// File: tb/tb_vga_stream_capture.sv
// Directed bench for vga_stream_capture using a scaled-down raster
// (24 cycles x 12 lines, H_BACK=4, H_ACTIVE=16, V_BACK=2, V_ACTIVE=6).
module tb_vga_stream_capture;

  localparam int PER = 24;
  localparam int NL  = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vs  = 1'b1;
  logic        hs  = 1'b1;
  logic        r = 1'b0, g = 1'b0, b = 1'b0;
  logic [25:0] str;
  logic        lk;
  logic [10:0] lp;
  logic [25:0] cap0, cap1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_stream_capture #(
    .H_ACTIVE    (16),
    .H_BACK      (4),
    .V_ACTIVE    (6),
    .V_BACK      (2),
    .H_TOL       (2),
    .LOCK_FRAMES (2)
  ) dut (
    .px_clk      (clk),
    .reset       (rst),
    .vsync_in    (vs),
    .hsync_in    (hs),
    .r_in        (r),
    .g_in        (g),
    .b_in        (b),
    .strRGB      (str),
    .locked      (lk),
    .line_period (lp)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One line: hsync rises at cycle 0, low for the last 2 cycles.
  // A white pixel at column wc; output sampled 3 and 4 cycles later.
  task automatic send_line(input int per, input logic v, input int wc);
    for (int c = 0; c < per; c++) begin
      @(negedge clk);
      if (wc >= 0 && c == wc + 3) cap0 = str;
      if (wc >= 0 && c == wc + 4) cap1 = str;
      hs = (c < per - 2);
      vs = v;
      {r, g, b} = (c == wc) ? 3'b111 : 3'b000;
    end
  endtask

  task automatic lines(input int n, input int per, input logic v);
    repeat (n) send_line(per, v, -1);
  endtask

  task automatic frame(input int n);
    lines(n - 1, PER, 1'b1);
    lines(1, PER, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_str", str, 26'h0300000);
      chk("rst_lock", lk, 0);
      chk("rst_lp", lp, 0);
    end
    rst = 1'b0;

    // Frame 1 carries no vsync edge; V0..V3 open frames 2..5.
    repeat (4) frame(NL);
    chk("prelock", lk, 0);
    send_line(PER, 1'b1, -1);
    chk("lock", lk, 1);
    chk("lp24", lp, 24);

    lines(3, PER, 1'b1);
    send_line(PER, 1'b1, 14);
    chk("white", cap0, {3'b111, 1'b1, 1'b1, 1'b1, 10'd2, 10'd10});
    chk("black", cap1, {3'b000, 1'b1, 1'b1, 1'b1, 10'd2, 10'd11});
    send_line(PER, 1'b1, 1);
    chk("porch", cap0, 26'h0300000);
    lines(5, PER, 1'b1);
    lines(1, PER, 1'b0);

    // Frame 6: +2 and -2 stay locked, +5 drops lock.
    send_line(PER, 1'b1, -1);
    send_line(26, 1'b1, -1);
    send_line(22, 1'b1, -1);
    send_line(29, 1'b1, -1);
    chk("tol_lock", lk, 1);
    chk("tol_lp", lp, 22);
    send_line(PER, 1'b1, 14);
    chk("bad_lock", lk, 0);
    chk("bad_lp", lp, 29);
    chk("bad_str", cap0, {3'b000, 1'b0, 1'b1, 1'b1, 10'd2, 10'd10});
    lines(6, PER, 1'b1);
    lines(1, PER, 1'b0);

    repeat (3) frame(NL);
    chk("re1_pre", lk, 0);
    lines(10, PER, 1'b1);
    chk("re1_lock", lk, 1);
    lines(1, PER, 1'b0);

    // Short frame ends at the next vsync edge.
    send_line(PER, 1'b1, -1);
    chk("short_lost", lk, 0);
    lines(10, PER, 1'b1);
    lines(1, PER, 1'b0);
    repeat (3) frame(NL);
    chk("re2_pre", lk, 0);
    send_line(PER, 1'b1, -1);
    chk("re2_lock", lk, 1);

    // hsync lost: counter pins at 2047.
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      hs = 1'b0;
      vs = 1'b1;
      {r, g, b} = 3'b000;
    end
    chk("sat_lock", lk, 0);
    chk("sat_str", str, 26'h0200000);
    send_line(PER, 1'b1, -1);
    chk("sat_lp", lp, 2047);
    chk("sat_lock2", lk, 0);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_str", str, 26'h0300000);
    chk("mid_rst_lp", lp, 0);
    chk("mid_rst_lock", lk, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
